// File: rtl/bwt_pkg.sv
// Shared types and constants for the BWT run loader slice.
// Optional padding support is enabled with `define BWT_RUN_PAD_EN.
package bwt_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] PAD_BYTE = 8'hFF;

  // rd_fifo bit indices
  localparam int RD_L = 1;
  localparam int RD_R = 0;

`ifdef BWT_RUN_PAD_EN
  typedef enum logic [2:0] {
    FILL_L,
    FILL_R,
    ISSUE,
    PAD,
    DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    FILL_L,
    FILL_R,
    ISSUE,
    DONE
  } state_t;
`endif

endpackage

// File: rtl/bwt_fwft_fifo.sv
// First-word-fall-through FIFO; head is driven combinationally, 0 when empty.
// Full/empty come from an occupancy counter, pointers wrap modulo DEPTH.
module bwt_fwft_fifo
  import bwt_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int VAR_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [VAR_LEN-1:0] LAST_IDX = VAR_LEN'(DEPTH - 1);
  localparam logic [VAR_LEN-1:0] DEPTH_V  = VAR_LEN'(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [VAR_LEN-1:0] wr_ptr;
  logic [VAR_LEN-1:0] rd_ptr;
  logic [VAR_LEN-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == DEPTH_V);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a simultaneous pop frees the slot the push needs
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + VAR_LEN'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + VAR_LEN'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + VAR_LEN'(1);
        2'b01:   count <= count - VAR_LEN'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bwt_run_loader.sv
// Splits a byte stream into RUN_LEN runs alternately loaded into left/right FWFT
// FIFOs and pulses start per pair. `define BWT_RUN_PAD_EN enables 8'hFF padding.
module bwt_run_loader
  import bwt_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int VAR_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [1:0]        rd_fifo,
  output logic [DATA_W-1:0] array_L,
  output logic [DATA_W-1:0] array_R,
  output logic              start,
  output logic              err
);

  localparam logic [VAR_LEN-1:0] RUN_END = VAR_LEN'(RUN_LEN - 1);

  state_t             state, state_n;
  logic [VAR_LEN-1:0] cnt, cnt_n;
  logic               last_r, last_n;
  logic               rdy;
  logic               push_l, push_r;
  logic               pop_l, pop_r;
  logic               full_l, full_r;
  logic               empty_l, empty_r;
  logic               set_err;
  logic               run_end;
  logic [DATA_W-1:0]  din_l, din_r;

`ifdef BWT_RUN_PAD_EN
  logic side_r, side_n;  // 0: padding the left run, 1: padding the right run
  logic pad_sel;
  assign din_l = pad_sel ? PAD_BYTE : in_data;
  assign din_r = pad_sel ? PAD_BYTE : in_data;
`else
  assign din_l = in_data;
  assign din_r = in_data;
`endif

  assign pop_l    = rd_fifo[RD_L];
  assign pop_r    = rd_fifo[RD_R];
  assign run_end  = (cnt == RUN_END);
  assign in_ready = rdy && !rst;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_r;
    rdy     = 1'b0;
    push_l  = 1'b0;
    push_r  = 1'b0;
    start   = 1'b0;
    set_err = 1'b0;
`ifdef BWT_RUN_PAD_EN
    side_n  = side_r;
    pad_sel = 1'b0;
`endif
    unique case (state)
      FILL_L: begin
        rdy = !full_l;
        if (in_valid && !full_l) begin
          push_l = 1'b1;
          if (in_last) begin
`ifdef BWT_RUN_PAD_EN
            state_n = PAD;
            side_n  = run_end;
            cnt_n   = run_end ? '0 : cnt + VAR_LEN'(1);
`else
            set_err = 1'b1;
            state_n = DONE;
            cnt_n   = '0;
`endif
          end else if (run_end) begin
            cnt_n   = '0;
            state_n = FILL_R;
          end else begin
            cnt_n = cnt + VAR_LEN'(1);
          end
        end
      end
      FILL_R: begin
        rdy = !full_r;
        if (in_valid && !full_r) begin
          push_r = 1'b1;
          if (run_end) begin
            cnt_n   = '0;
            last_n  = in_last;
            state_n = ISSUE;
          end else if (in_last) begin
`ifdef BWT_RUN_PAD_EN
            state_n = PAD;
            side_n  = 1'b1;
            cnt_n   = cnt + VAR_LEN'(1);
`else
            set_err = 1'b1;
            state_n = DONE;
            cnt_n   = '0;
`endif
          end else begin
            cnt_n = cnt + VAR_LEN'(1);
          end
        end
      end
      ISSUE: begin
        start   = 1'b1;
        last_n  = 1'b0;
        state_n = last_r ? DONE : FILL_L;
      end
`ifdef BWT_RUN_PAD_EN
      PAD: begin
        pad_sel = 1'b1;
        // pad pushes stall while the target FIFO is full
        if (!side_r && !full_l) begin
          push_l = 1'b1;
          if (run_end) begin
            cnt_n  = '0;
            side_n = 1'b1;
          end else begin
            cnt_n = cnt + VAR_LEN'(1);
          end
        end else if (side_r && !full_r) begin
          push_r = 1'b1;
          if (run_end) begin
            cnt_n   = '0;
            last_n  = 1'b1;
            state_n = ISSUE;
          end else begin
            cnt_n = cnt + VAR_LEN'(1);
          end
        end
      end
`endif
      DONE: begin
        if (empty_l && empty_r) begin
          state_n = FILL_L;
        end
      end
      default: begin
        state_n = FILL_L;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL_L;
      cnt    <= '0;
      last_r <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      last_r <= last_n;
      if (set_err || (pop_l && empty_l) || (pop_r && empty_r)) begin
        err <= 1'b1;
      end
    end
  end

`ifdef BWT_RUN_PAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      side_r <= 1'b0;
    end else begin
      side_r <= side_n;
    end
  end
`endif

  bwt_fwft_fifo #(
    .DEPTH  (2 * RUN_LEN),
    .VAR_LEN(VAR_LEN)
  ) u_fifo_l (
    .clk  (clk),
    .rst  (rst),
    .push (push_l),
    .pop  (pop_l),
    .din  (din_l),
    .dout (array_L),
    .full (full_l),
    .empty(empty_l)
  );

  bwt_fwft_fifo #(
    .DEPTH  (2 * RUN_LEN),
    .VAR_LEN(VAR_LEN)
  ) u_fifo_r (
    .clk  (clk),
    .rst  (rst),
    .push (push_r),
    .pop  (pop_r),
    .din  (din_r),
    .dout (array_R),
    .full (full_r),
    .empty(empty_r)
  );

endmodule

// File: tb/tb_bwt_run_loader.sv
// Scoreboard bench for bwt_run_loader; padding scenario follows BWT_RUN_PAD_EN.
module tb_bwt_run_loader;

  localparam int RUN_LEN = 2;
  localparam int VAR_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [1:0] rd_fifo = '0;
  logic [7:0] array_L;
  logic [7:0] array_R;
  logic       start;
  logic       err;

  int n_checks = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int pos = 0;
  logic [7:0] qL[$];
  logic [7:0] qR[$];

  always #5 clk = ~clk;

  bwt_run_loader #(
    .RUN_LEN(RUN_LEN),
    .VAR_LEN(VAR_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .rd_fifo (rd_fifo),
    .array_L (array_L),
    .array_R (array_R),
    .start   (start),
    .err     (err)
  );

  always @(posedge clk) begin
    if (start === 1'b1) start_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] head_l();
    if (qL.size() != 0) return qL[0];
    return 8'h00;
  endfunction

  function automatic logic [7:0] head_r();
    if (qR.size() != 0) return qR[0];
    return 8'h00;
  endfunction

  task automatic clear_model();
    qL.delete();
    qR.delete();
    pos = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; rd_fifo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
  endtask

  // waits (bounded) for the byte to be accepted, then records it in the scoreboard
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit ok;
    ok = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) ok = 1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_byte_%h: in_ready=%b, required 1 within 40 cycles", d, in_ready);
    end else begin
      if ((pos % (2 * RUN_LEN)) < RUN_LEN) qL.push_back(d);
      else qR.push_back(d);
      pos++;
    end
  endtask

  task automatic pop_fifo(input logic [1:0] r);
    rd_fifo = r;
    @(posedge clk); #1;
    rd_fifo = '0;
    if (r[1] && qL.size() != 0) void'(qL.pop_front());
    if (r[0] && qR.size() != 0) void'(qR.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, expected 0", start); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
    n_checks++; if (array_L !== 8'h00) begin n_fail++; $display("FAIL reset_array_L: got %h, expected 00", array_L); end
    n_checks++; if (array_R !== 8'h00) begin n_fail++; $display("FAIL reset_array_R: got %h, expected 00", array_R); end
    rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fill_l_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_basic_pair();
    do_reset();
    send_byte(8'd3, 1'b0);
    send_byte(8'd7, 1'b0);
    send_byte(8'd1, 1'b0);
    send_byte(8'd9, 1'b1);
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b, expected 1", start); end
    n_checks++; if (array_L !== head_l()) begin n_fail++; $display("FAIL basic_head_L: got %h, expected %h", array_L, head_l()); end
    n_checks++; if (array_R !== head_r()) begin n_fail++; $display("FAIL basic_head_R: got %h, expected %h", array_R, head_r()); end
    @(posedge clk); #1;
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL basic_start_pulse: got %b, expected 0", start); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_ready: got %b, expected 0", in_ready); end
    pop_fifo(2'b10);
    n_checks++; if (array_L !== head_l()) begin n_fail++; $display("FAIL basic_pop_L: got %h, expected %h", array_L, head_l()); end
    pop_fifo(2'b01);
    n_checks++; if (array_R !== head_r()) begin n_fail++; $display("FAIL basic_pop_R: got %h, expected %h", array_R, head_r()); end
    pop_fifo(2'b11);
    n_checks++; if (array_L !== 8'h00 || array_R !== 8'h00) begin n_fail++; $display("FAIL basic_drained: got L=%h R=%h, expected 00 00", array_L, array_R); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b, expected 0", err); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_to_fill: got %b, expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int s0;
    logic [1:0] r;
    do_reset();
    s0 = start_cnt;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
    @(posedge clk); #1;
    n_checks++; if (start_cnt - s0 != 2) begin n_fail++; $display("FAIL bp_start_count: got %0d, expected 2", start_cnt - s0); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b, expected 0", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %b, expected 0", in_ready); end
    n_checks++; if (array_L !== head_l() || array_R !== head_r()) begin n_fail++; $display("FAIL bp_heads: got L=%h R=%h, expected %h %h", array_L, array_R, head_l(), head_r()); end
    pop_fifo(2'b10);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop_ready: got %b, expected 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      if (qL.size() == 0 && qR.size() == 0) break;
      n_checks++; if (array_L !== head_l() || array_R !== head_r()) begin n_fail++; $display("FAIL bp_drain_%0d: got L=%h R=%h, expected %h %h", i, array_L, array_R, head_l(), head_r()); end
      r = {qL.size() != 0, qR.size() != 0};
      pop_fifo(r);
    end
    n_checks++; if (array_L !== 8'h00 || array_R !== 8'h00) begin n_fail++; $display("FAIL bp_empty: got L=%h R=%h, expected 00 00", array_L, array_R); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b, expected 0", err); end
  endtask

`ifdef BWT_RUN_PAD_EN
  task automatic test_padding();
    bit seen;
    do_reset();
    send_byte(8'd5, 1'b0);
    send_byte(8'd2, 1'b0);
    send_byte(8'd4, 1'b1);
    qR.push_back(8'hFF);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (start === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL pad_start: got start=%b, expected 1 within 10 cycles", start); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL pad_err: got %b, expected 0", err); end
    n_checks++; if (array_L !== head_l() || array_R !== head_r()) begin n_fail++; $display("FAIL pad_heads: got L=%h R=%h, expected %h %h", array_L, array_R, head_l(), head_r()); end
    pop_fifo(2'b01);
    n_checks++; if (array_R !== head_r()) begin n_fail++; $display("FAIL pad_byte: got %h, expected %h", array_R, head_r()); end
  endtask
`else
  task automatic test_no_padding();
    int s0;
    do_reset();
    s0 = start_cnt;
    send_byte(8'd5, 1'b0);
    send_byte(8'd2, 1'b0);
    send_byte(8'd4, 1'b1);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL nopad_err: got %b, expected 1", err); end
    n_checks++; if (array_R !== head_r()) begin n_fail++; $display("FAIL nopad_array_R: got %h, expected %h", array_R, head_r()); end
    n_checks++; if (array_L !== head_l()) begin n_fail++; $display("FAIL nopad_array_L: got %h, expected %h", array_L, head_l()); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL nopad_done_ready: got %b, expected 0", in_ready); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL nopad_no_start: got %0d pulses, expected 0", start_cnt - s0); end
  endtask
`endif

  task automatic test_empty_pop();
    do_reset();
    pop_fifo(2'b10);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL empty_pop_err: got %b, expected 1", err); end
    n_checks++; if (array_L !== head_l()) begin n_fail++; $display("FAIL empty_pop_array_L: got %h, expected %h", array_L, head_l()); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0 || start !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got ready=%b start=%b err=%b, expected 0 0 0", in_ready, start, err); end
    n_checks++; if (array_L !== 8'h00 || array_R !== 8'h00) begin n_fail++; $display("FAIL midrst_heads: got L=%h R=%h, expected 00 00", array_L, array_R); end
    rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    send_byte(8'd3, 1'b0);
    send_byte(8'd7, 1'b0);
    send_byte(8'd1, 1'b0);
    send_byte(8'd9, 1'b1);
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL midrst_start: got %b, expected 1", start); end
    n_checks++; if (array_L !== head_l() || array_R !== head_r()) begin n_fail++; $display("FAIL midrst_heads_after: got L=%h R=%h, expected %h %h", array_L, array_R, head_l(), head_r()); end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_back_to_back();
`ifdef BWT_RUN_PAD_EN
    test_padding();
`else
    test_no_padding();
`endif
    test_empty_pop();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bwt_run_loader.md
# bwt_run_loader

Upstream feeder for the `sort_arrays` merge stage in the BWT sort path. It accepts a byte stream with a valid/ready handshake and splits it into fixed-length runs. Runs go alternately into two internal first-word-fall-through FIFOs (left, right). Once one full left run and one full right run are loaded, it pulses `start`, then serves `array_L`/`array_R` heads and pops on the merger's `rd_fifo` requests.

## Interface
- `RUN_LEN`, 2: bytes per run; equals the merger's `INPUT_ARR_LEN`.
- `VAR_LEN`, 4: width of the run and pointer counters; must satisfy 2^VAR_LEN > 2*RUN_LEN.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` valid.
- `in_last` input 1: marks the final byte of the stream; qualified by `in_valid`.
- `in_ready` output 1: byte accepted on a cycle where `in_valid && in_ready`.
- `rd_fifo` input 2: pop requests; bit 1 pops the left FIFO, bit 0 pops the right FIFO.
- `array_L` output 8: left FIFO head; 8'h00 when empty.
- `array_R` output 8: right FIFO head; 8'h00 when empty.
- `start` output 1: one-cycle pulse; a left/right run pair is ready.
- `err` output 1: sticky protocol error flag.

## Operation
- Each FIFO has depth 2*RUN_LEN, so the next pair loads while the current pair merges.
- Reset values: `in_ready`=0, `start`=0, `err`=0, `array_L`/`array_R`=8'h00, both FIFOs empty, `cnt`=0, state FILL_L.
- FSM states: FILL_L, FILL_R, ISSUE, PAD, DONE.
- **FILL_L**
  - `in_ready` = !left_full.
  - Each accepted byte is pushed to the left FIFO and `cnt++`.
  - At `cnt==RUN_LEN-1`: `cnt`←0, go to FILL_R.
- **FILL_R**
  - Same as FILL_L, using the right FIFO.
  - At run end, go to ISSUE.
- **ISSUE**
  - `in_ready`=0; assert `start` for this single cycle.
  - Go to FILL_L, or to DONE if the byte just loaded carried `in_last`.
- **`in_last` on a run boundary** (the last byte of a right run): normal ISSUE, then DONE.
- **`in_last` mid-run** is handled by the PAD state (see Configuration).
- **DONE**
  - `in_ready`=0.
  - Returns to FILL_L once both FIFOs are empty.
- **Pops**
  - A pop of an empty FIFO is ignored and sets `err`.
  - A push and a pop on the same FIFO in the same cycle are both performed; occupancy is unchanged.
- **Counter arithmetic**: all counters are VAR_LEN bits and unsigned. Pointers wrap modulo 2*RUN_LEN, and full/empty come from a separate occupancy count, not pointer compare.
- **Mid-operation reset**: `rst` clears the FIFOs, FSM and flags on the next edge; partial runs are discarded.

## Timing
- A byte accepted at edge N is visible on `array_L`/`array_R` after edge N if the FIFO was empty; otherwise it waits behind earlier entries.
- `start` is high in the cycle after the final right-run byte is written, so both heads are valid while `start`=1.
- A pop at edge N presents the next entry after edge N (first-word-fall-through, zero extra latency).
- `in_ready` is combinational from the state and the full flags; it never depends on `in_valid`.
- Throughput is 1 byte/cycle, except 1 bubble per pair (ISSUE).

## Configuration
- `BWT_RUN_PAD_EN` defined:
  - `in_last` mid-run, or at the end of a left run, enters PAD.
  - PAD pushes 8'hFF, one per cycle with `in_ready`=0, until the left and right runs are both complete.
  - Then ISSUE, then DONE.
  - Pad bytes sort last, so the merged output keeps real data first.
- `BWT_RUN_PAD_EN` undefined:
  - The PAD state is absent.
  - `in_last` anywhere other than the last byte of a right run sets `err`.
  - The partial run stays in the FIFO, no `start` is issued, and the FSM goes to DONE.

## Structure
- Shared package `bwt_pkg`:
  - `DATA_W`=8.
  - `PAD_BYTE`=8'hFF.
  - The FSM state enum type.
  - The `RD_L`=1 / `RD_R`=0 bit indices of `rd_fifo`.
- One sub-module, `bwt_fwft_fifo`:
  - Parameters DEPTH and VAR_LEN.
  - Ports `clk`, `rst`, push, pop, `din`, `dout`, `full`, `empty`.
  - Instantiated twice, for left and right.

## Test plan
- **Basic pair**: RUN_LEN=2, stream 3,7,1,9 with `in_last` on 9 → `start` pulse one cycle after 9 is accepted, with `array_L`=3 and `array_R`=1; popping L then R yields 7 then 9; FSM reaches DONE.
- **Back-pressure**: hold `rd_fifo`=0 and stream 8 bytes → `in_ready` drops after byte 8 (both FIFOs full), with 2 `start` pulses; one left pop raises `in_ready` only once the FSM is back in FILL_L.
- **Padding**: with `BWT_RUN_PAD_EN`, stream 5,2,4 with `in_last` on 4 → right FIFO holds 4,FF; `start` pulses; `err`=0.
- **No padding**: same stimulus without the macro → `err`=1, no `start`, `array_R`=4.
- **Empty pop**: `rd_fifo`=2'b10 after reset → `err`=1; `array_L` stays 8'h00.
- **Mid-operation reset**: assert `rst` after 3 bytes → next cycle all outputs are at reset values; a new 4-byte stream behaves as in the basic-pair scenario.
